video_timing_gen: RTL and testbench

Parametrised raster timing generator for the display path. It produces registered de, hsync and vsync, pixel coordinates, and frame, line and programmable-line event pulses. It is driven by a pixel-rate clock enable, so one clock domain can serve several pixel rates. It sits ahead of the pixel source and the TMDS/VGA output stage and is the common timing source for every video mode.

---
 rtl/video_timing_gen.sv | 127 ++++++++++++
 tb/tb_video_timing_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Parametrised raster timing generator. Walks an (h,v) raster
//             under a pixel clock enable and registers de, hsync, vsync,
//             pixel coordinates and frame/line/programmable-line event pulses.
//  Ports    : clk       - clock
//             rst       - synchronous active-high reset
//             ce        - pixel clock enable (raster advances when 1)
//             irq_line  - line number that raises line_irq at its start
//             de        - active video
//             hsync     - horizontal sync (HS_POL level when active)
//             vsync     - vertical sync (VS_POL level when active)
//             x, y      - raw raster position of the current output pixel
//             sof       - start-of-frame pulse (pixel 0,0)
//             eol       - last active pixel of a visible line
//             line_irq  - pulse at pixel 0 of line irq_line
//             vblank    - vertical blanking (y >= V_ACTIVE)
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [CNT_W-1:0] irq_line,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             sof,
    output logic             eol,
    output logic             line_irq,
    output logic             vblank
);

    // Raster boundaries, pre-sized to the counter width
    localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_h_eol    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_hs_start = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_vs_start = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_h_wrap;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_vblank;
    logic             w_sof;
    logic             w_eol;
    logic             w_irq;

    // Decode of the current raster position; registered on the ce edge
    always_comb begin
        w_h_wrap = (r_h == c_h_last);
        w_h_next = w_h_wrap ? '0 : r_h + 1'b1;
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end
        w_vblank = (r_v >= c_v_act);
        w_de     = (r_h < c_h_act) && !w_vblank;
        w_hs_act = (r_h >= c_hs_start) && (r_h < c_hs_end);
        // vsync is decoded from v only, so its edges fall on h=0
        w_vs_act = (r_v >= c_vs_start) && (r_v < c_vs_end);
        w_sof    = (r_h == '0) && (r_v == '0);
        w_eol    = (r_h == c_h_eol) && !w_vblank;
        // A line number beyond the raster is simply never matched
        w_irq    = (r_h == '0) && (r_v == irq_line);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h      <= '0;
            r_v      <= '0;
            de       <= 1'b0;
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            x        <= '0;
            y        <= '0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            line_irq <= 1'b0;
            vblank   <= 1'b0;
        end else if (ce) begin
            r_h      <= w_h_next;
            r_v      <= w_v_next;
            de       <= w_de;
            hsync    <= w_hs_act ? HS_POL : ~HS_POL;
            vsync    <= w_vs_act ? VS_POL : ~VS_POL;
            x        <= r_h;
            y        <= r_v;
            sof      <= w_sof;
            eol      <= w_eol;
            line_irq <= w_irq;
            vblank   <= w_vblank;
        end else begin
            // Levels hold; event pulses drop so each is one clk wide
            sof      <= 1'b0;
            eol      <= 1'b0;
            line_irq <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Directed self-checking bench for video_timing_gen using a
//             16x8 raster (8 active pixels, 4 active lines, 128 pixels/frame),
//             hsync active-low, vsync active-high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic [CNT_W-1:0] irq_line;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             sof;
    logic             eol;
    logic             line_irq;
    logic             vblank;

    int n_chk  = 0;
    int n_fail = 0;

    // Pulse tallies filled by scan_frames
    int sof_n;
    int eol_n;
    int irq_n;

    video_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .HS_POL   (1'b0),
        .VS_POL   (1'b1),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .irq_line (irq_line),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .x        (x),
        .y        (y),
        .sof      (sof),
        .eol      (eol),
        .line_irq (line_irq),
        .vblank   (vblank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_de"},    32'(de),       0);
        chk({tag, "_hsync"}, 32'(hsync),    1);
        chk({tag, "_vsync"}, 32'(vsync),    0);
        chk({tag, "_x"},     32'(x),        0);
        chk({tag, "_y"},     32'(y),        0);
        chk({tag, "_sof"},   32'(sof),      0);
        chk({tag, "_eol"},   32'(eol),      0);
        chk({tag, "_irq"},   32'(line_irq), 0);
        chk({tag, "_vblk"},  32'(vblank),   0);
    endtask

    // Hold reset with ce low, then release with ce high: the next edge
    // samples raster position 0.
    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        ce  = 1'b1;
    endtask

    // Runs ncyc clocks from a fresh reset. With alt set, ce is 1 on even
    // clocks and 0 on odd ones, so clock k shows raster index k/2 and the
    // pulses only appear on even clocks. Expected levels come from the
    // hand-derived 16x8 raster map; each signal's mismatches are tallied.
    task automatic scan_frames(input string tag, input int ncyc, input bit alt, input int irq);
        int e_pos, e_de, e_hs, e_vs, e_vb, e_sof, e_eol, e_irq, e_ovl;
        int p, eh, ev;
        bit fresh;
        e_pos = 0; e_de = 0; e_hs = 0; e_vs = 0; e_vb = 0;
        e_sof = 0; e_eol = 0; e_irq = 0; e_ovl = 0;
        sof_n = 0; eol_n = 0; irq_n = 0;
        for (int k = 0; k < ncyc; k++) begin
            ce = alt ? (k % 2 == 0) : 1'b1;
            tick();
            p     = (alt ? k / 2 : k) % 128;
            fresh = !alt || (k % 2 == 0);
            eh    = p % 16;
            ev    = p / 16;
            if (x !== CNT_W'(eh) || y !== CNT_W'(ev)) e_pos++;
            if (de !== (eh < 8 && ev < 4)) e_de++;
            if (hsync !== !(eh >= 10 && eh <= 12)) e_hs++;
            if (vsync !== (ev == 5 || ev == 6)) e_vs++;
            if (vblank !== (ev >= 4)) e_vb++;
            if (sof !== (fresh && p == 0)) e_sof++;
            if (eol !== (fresh && eh == 7 && ev < 4)) e_eol++;
            if (line_irq !== (fresh && eh == 0 && ev == irq)) e_irq++;
            if (de === 1'b1 && (hsync !== 1'b1 || vsync !== 1'b0)) e_ovl++;
            sof_n += int'(sof);
            eol_n += int'(eol);
            irq_n += int'(line_irq);
        end
        chk({tag, "_pos_err"},   e_pos, 0);
        chk({tag, "_de_err"},    e_de,  0);
        chk({tag, "_hsync_err"}, e_hs,  0);
        chk({tag, "_vsync_err"}, e_vs,  0);
        chk({tag, "_vblank_err"},e_vb,  0);
        chk({tag, "_sof_err"},   e_sof, 0);
        chk({tag, "_eol_err"},   e_eol, 0);
        chk({tag, "_irq_err"},   e_irq, 0);
        chk({tag, "_sync_de"},   e_ovl, 0);
    endtask

    initial begin
        int first_hit;
        rst      = 1'b1;
        ce       = 1'b0;
        irq_line = CNT_W'(2);

        // Reset state
        repeat (3) tick();
        chk_reset("rst");

        // First output after release is (0,0) with sof
        rst = 1'b0;
        ce  = 1'b1;
        tick();
        chk("first_x",   32'(x),   0);
        chk("first_y",   32'(y),   0);
        chk("first_de",  32'(de),  1);
        chk("first_sof", 32'(sof), 1);

        // Two continuous frames, irq_line=2
        do_reset();
        scan_frames("cont", 256, 1'b0, 2);
        chk("cont_sof_n", sof_n, 2);
        chk("cont_eol_n", eol_n, 8);
        chk("cont_irq_n", irq_n, 2);

        // ce alternating: frame period doubles, pulses stay single-clock
        do_reset();
        scan_frames("alt", 512, 1'b1, 2);
        chk("alt_sof_n", sof_n, 2);
        chk("alt_eol_n", eol_n, 8);
        chk("alt_irq_n", irq_n, 2);

        // irq_line beyond the raster never fires
        irq_line = CNT_W'(9);
        do_reset();
        scan_frames("irq9", 128, 1'b0, 9);
        chk("irq9_n", irq_n, 0);

        // irq_line 2 -> 6 while line 3 is being output
        irq_line = CNT_W'(2);
        do_reset();
        first_hit = -1;
        irq_n     = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (k == 48) irq_line = CNT_W'(6);
            if (k > 48 && line_irq === 1'b1) begin
                irq_n++;
                if (first_hit < 0) first_hit = k;
            end
        end
        chk("irqchg_hit_idx", first_hit, 96);
        chk("irqchg_n",       irq_n,     1);

        // Mid-frame reset at (5,3)
        irq_line = CNT_W'(2);
        do_reset();
        repeat (54) tick();
        chk("mid_x", 32'(x), 5);
        chk("mid_y", 32'(y), 3);
        rst = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        tick();
        chk("rel_x",   32'(x),   0);
        chk("rel_y",   32'(y),   0);
        chk("rel_sof", 32'(sof), 1);
        chk("rel_de",  32'(de),  1);

        // Line and frame wrap
        do_reset();
        repeat (64) tick();
        chk("w3_x", 32'(x), 15);
        chk("w3_y", 32'(y), 3);
        tick();
        chk("w4_x",  32'(x),  0);
        chk("w4_y",  32'(y),  4);
        chk("w4_de", 32'(de), 0);
        repeat (63) tick();
        chk("w7_x", 32'(x), 15);
        chk("w7_y", 32'(y), 7);
        tick();
        chk("w0_x",   32'(x),   0);
        chk("w0_y",   32'(y),   0);
        chk("w0_sof", 32'(sof), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
